// File: rtl/mult_seq_pkg.sv
// Shared helpers for the sequential shift-add multiplier.
// Sizes the iteration counter from the operand width.
package mult_seq_pkg;

  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain N-bit adder used for the partial-product accumulate.
// Callers size N so the carry out always fits.
module adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/mult_seq.sv
// Sequential unsigned shift-add multiplier, one bit per cycle.
// IDLE -> RUN (WIDTH cycles) -> DONE (one cycle) -> IDLE.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_bits(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH:0]       r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_mcand;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_shift;

  assign w_addend = r_lo[0] ? {1'b0, r_mcand} : '0;

  adder_nbit #(
    .N (WIDTH + 1)
  ) u_add (
    .i_a   (r_hi),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );

  assign w_shift = {w_sum, r_lo} >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_hi    <= '0;
            r_lo    <= b;
            r_mcand <= a;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_hi  <= w_shift[2*WIDTH:WIDTH];
          r_lo  <= w_shift[WIDTH-1:0];
          r_cnt <= r_cnt + CW'(1);
          // last shift: result is taken straight from this edge's shift
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_product <= w_shift[2*WIDTH-1:0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq at WIDTH=32 and WIDTH=4.
// Expected products queue on start and are checked on done.
module tb_mult_seq;

  logic        clk;
  logic        rst;
  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [63:0] product32;
  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int total = 0;
  int bad = 0;

  logic [63:0] q32[$];
  logic [63:0] q4[$];
  logic [63:0] last32 = '0;
  logic [7:0]  last4 = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tv[6];

  mult_seq #(.WIDTH(32)) u_m32 (
    .clk     (clk),
    .rst     (rst),
    .start   (start32),
    .a       (a32),
    .b       (b32),
    .busy    (busy32),
    .done    (done32),
    .product (product32)
  );

  mult_seq #(.WIDTH(4)) u_m4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done32) begin
        if (q32.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done32 act=1 exp=0");
        end else begin
          chk("prod32", product32, q32.pop_front());
        end
        last32 = product32;
      end
      if (busy32) chk("hold32", product32, last32);
      chk("excl32", 64'(busy32 & done32), 64'd0);
      if (done4) begin
        if (q4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done4 act=1 exp=0");
        end else begin
          chk("prod4", 64'(product4), q4.pop_front());
        end
        last4 = product4;
      end
      if (busy4) chk("hold4", 64'(product4), 64'(last4));
      chk("excl4", 64'(busy4 & done4), 64'd0);
    end
  end

  task automatic op32(input logic [31:0] ia,
                      input logic [31:0] ib,
                      input logic [63:0] exp,
                      input int inj,
                      input int rstc);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    a32 = ia;
    b32 = ib;
    start32 = 1'b1;
    q32.push_back(exp);
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done32) begin
        got = 1'b1;
        break;
      end
      if (busy32) n++;
      if (inj != 0 && n == inj + 1 && start32) begin
        start32 = 1'b0;
      end else if (inj != 0 && n == inj) begin
        start32 = 1'b1;
        a32 = 32'd7;
        b32 = 32'd9;
      end
      if (rstc != 0 && n == rstc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_prod", product32, 64'd0);
        q32.delete();
        last32 = '0;
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("done32_seen", 64'(got), 64'd1);
    chk("busy_len32", 64'(n), 64'd32);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done4();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done4) begin
        got = 1'b1;
        break;
      end
    end
    chk("done4_seen", 64'(got), 64'd1);
  endtask

  initial begin
    int p;
    tv[0] = '{32'd3, 32'd5, 64'd15};
    tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tv[2] = '{32'h8000_0000, 32'd2, 64'h1_0000_0000};
    tv[3] = '{32'd0, 32'h1234, 64'd0};
    tv[4] = '{32'h1234, 32'd0, 64'd0};
    tv[5] = '{32'd1, 32'hDEAD_BEEF, 64'hDEAD_BEEF};

    rst = 1'b1;
    start32 = 1'b0;
    start4 = 1'b0;
    a32 = '0;
    b32 = '0;
    a4 = '0;
    b4 = '0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_busy32", 64'(busy32), 64'd0);
    chk("reset_done32", 64'(done32), 64'd0);
    chk("reset_prod32", product32, 64'd0);
    chk("reset_busy4", 64'(busy4), 64'd0);
    chk("reset_prod4", 64'(product4), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) op32(tv[i].a, tv[i].b, tv[i].p, 0, 0);

    op32(32'd100, 32'd200, 64'd20000, 10, 0);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;

    op32(32'd5, 32'd6, 64'd30, 0, 16);
    op32(32'd12345, 32'd6789, 64'd83810205, 0, 0);

    a4 = 4'd15;
    b4 = 4'd15;
    start4 = 1'b1;
    q4.push_back(64'd225);
    @(posedge clk);
    #1;
    a4 = 4'd7;
    b4 = 4'd9;
    q4.push_back(64'd63);
    wait_done4();
    @(negedge clk);
    chk("gap_idle4", 64'({busy4, done4}), 64'd0);
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("gap_busy4", 64'(busy4), 64'd1);
    wait_done4();
    @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      p = int'(a4) * int'(b4);
      q4.push_back(64'(p));
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      wait_done4();
      @(posedge clk);
      #1;
    end

    repeat (5) @(negedge clk);
    chk("pending", 64'(q32.size() + q4.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
